// File: rtl/mac_block_sequencer.sv
// Streams (act, weight, select) beats into one external MAC unit, one block at a
// time. At each block end it pulses Block_control low for one cycle, captures the
// four partial sums, and presents them with the beat count on a result port.
module mac_block_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SELECT_WIDTH = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_act,
  input  logic [DATA_WIDTH-1:0]     in_weight,
  input  logic [SELECT_WIDTH-1:0]   in_sel,
  input  logic                      in_last,
  output logic [DATA_WIDTH-1:0]     mac_act,
  output logic [DATA_WIDTH-1:0]     mac_weight,
  output logic [SELECT_WIDTH-1:0]   mac_select,
  output logic                      mac_block,
  input  logic [4*DATA_WIDTH-1:0]   mac_out_0,
  input  logic [4*DATA_WIDTH-1:0]   mac_out_1,
  input  logic [4*DATA_WIDTH-1:0]   mac_out_2,
  input  logic [4*DATA_WIDTH-1:0]   mac_out_3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*DATA_WIDTH-1:0]   out_psum_0,
  output logic [4*DATA_WIDTH-1:0]   out_psum_1,
  output logic [4*DATA_WIDTH-1:0]   out_psum_2,
  output logic [4*DATA_WIDTH-1:0]   out_psum_3,
  output logic [CNT_WIDTH-1:0]      out_count,
  output logic                      busy
);

  localparam int unsigned SUM_WIDTH = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0]     mac_act_d, mac_weight_d;
  logic [SELECT_WIDTH-1:0]   mac_select_d;
  logic                      mac_block_d;
  logic                      out_valid_d;
  logic [SUM_WIDTH-1:0]      psum0_d, psum1_d, psum2_d, psum3_d;
  logic [CNT_WIDTH-1:0]      out_count_d;
  logic                      fire;

  // Handshake and status decode from registered state.
  assign in_ready = (state_q == ACC);
  assign fire     = in_valid & in_ready;
  assign busy     = (state_q != ACC) || (count_q != '0);

  // State, MAC drive and result registers.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_q    <= ACC;
      count_q    <= '0;
      mac_act    <= '0;
      mac_weight <= '0;
      mac_select <= '0;
      mac_block  <= 1'b0;
      out_valid  <= 1'b0;
      out_psum_0 <= '0;
      out_psum_1 <= '0;
      out_psum_2 <= '0;
      out_psum_3 <= '0;
      out_count  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mac_act    <= mac_act_d;
      mac_weight <= mac_weight_d;
      mac_select <= mac_select_d;
      mac_block  <= mac_block_d;
      out_valid  <= out_valid_d;
      out_psum_0 <= psum0_d;
      out_psum_1 <= psum1_d;
      out_psum_2 <= psum2_d;
      out_psum_3 <= psum3_d;
      out_count  <= out_count_d;
    end
  end

  // Next-state and next register values.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mac_act_d    = mac_act;
    mac_weight_d = mac_weight;
    mac_select_d = mac_select;
    mac_block_d  = mac_block;
    out_valid_d  = out_valid;
    psum0_d      = out_psum_0;
    psum1_d      = out_psum_1;
    psum2_d      = out_psum_2;
    psum3_d      = out_psum_3;
    out_count_d  = out_count;

    // Consumer takes the result; a same-edge capture below overrides this.
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ACC: begin
        mac_block_d = 1'b1;
        if (fire) begin
          mac_act_d    = in_act;
          mac_weight_d = in_weight;
          mac_select_d = in_sel;
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          if (in_last) begin
            state_d = FLUSH;
          end
        end else begin
          // Zero-product bubble leaves the accumulators untouched.
          mac_act_d    = '0;
          mac_weight_d = '0;
        end
      end
      FLUSH: begin
        mac_act_d    = '0;
        mac_weight_d = '0;
        mac_block_d  = 1'b1;
        if (!out_valid || out_ready) begin
          mac_block_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        psum0_d     = mac_out_0;
        psum1_d     = mac_out_1;
        psum2_d     = mac_out_2;
        psum3_d     = mac_out_3;
        out_count_d = count_q;
        out_valid_d = 1'b1;
        count_d     = '0;
        mac_block_d = 1'b1;
        state_d     = ACC;
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_block_sequencer.sv
// Self-checking bench: behavioural MAC attached to the sequencer, directed block
// scenarios followed by random blocks, results scored against a per-block model.
module tb_mac_block_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 16;

  logic            Clk;
  logic            rst;
  logic            in_valid, in_ready, in_last;
  logic [DW-1:0]   in_act, in_weight;
  logic [SW-1:0]   in_sel;
  logic [DW-1:0]   mac_act, mac_weight;
  logic [SW-1:0]   mac_select;
  logic            mac_block;
  logic [4*DW-1:0] mac_out_0, mac_out_1, mac_out_2, mac_out_3;
  logic            out_valid, out_ready;
  logic [4*DW-1:0] out_psum_0, out_psum_1, out_psum_2, out_psum_3;
  logic [CW-1:0]   out_count;
  logic            busy;

  mac_block_sequencer #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
    .in_sel(in_sel), .in_last(in_last),
    .mac_act(mac_act), .mac_weight(mac_weight), .mac_select(mac_select), .mac_block(mac_block),
    .mac_out_0(mac_out_0), .mac_out_1(mac_out_1), .mac_out_2(mac_out_2), .mac_out_3(mac_out_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum_0(out_psum_0), .out_psum_1(out_psum_1), .out_psum_2(out_psum_2), .out_psum_3(out_psum_3),
    .out_count(out_count), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural MAC: Block_control low clears, high accumulates into Select.
  logic [4*DW-1:0] acc [4];
  always @(posedge Clk) begin
    if (!mac_block) begin
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else begin
      acc[mac_select] <= acc[mac_select] + 32'(mac_act) * 32'(mac_weight);
    end
  end
  assign mac_out_0 = acc[0];
  assign mac_out_1 = acc[1];
  assign mac_out_2 = acc[2];
  assign mac_out_3 = acc[3];

  // Block-level reference: sums per accumulator and beat count per block.
  typedef struct packed {
    logic [31:0] p0, p1, p2, p3;
    logic [15:0] cnt;
  } res_t;

  res_t        exp_q [$];
  logic [31:0] m_ps [4];
  int          m_n;

  task automatic model_clear_block();
    for (int k = 0; k < 4; k++) m_ps[k] = '0;
    m_n = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] a, input logic [DW-1:0] w,
                            input logic [SW-1:0] s, input logic last);
    res_t r;
    m_ps[s] = m_ps[s] + 32'(a) * 32'(w);
    m_n++;
    if (last) begin
      r.p0  = m_ps[0];
      r.p1  = m_ps[1];
      r.p2  = m_ps[2];
      r.p3  = m_ps[3];
      r.cnt = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
      exp_q.push_back(r);
      model_clear_block();
    end
  endtask

  // Result monitor: scores every handshake and checks hold stability.
  res_t            mon_r;
  logic            hold_prev = 1'b0;
  logic [4*DW-1:0] prev_p0, prev_p1, prev_p2, prev_p3;
  logic [CW-1:0]   prev_cnt;

  always @(negedge Clk) begin
    if (rst) begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_psum0", 64'(out_psum_0), 64'(prev_p0));
        chk("hold_psum1", 64'(out_psum_1), 64'(prev_p1));
        chk("hold_psum2", 64'(out_psum_2), 64'(prev_p2));
        chk("hold_psum3", 64'(out_psum_3), 64'(prev_p3));
        chk("hold_count", 64'(out_count), 64'(prev_cnt));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          mon_r = exp_q.pop_front();
          chk("psum0", 64'(out_psum_0), 64'(mon_r.p0));
          chk("psum1", 64'(out_psum_1), 64'(mon_r.p1));
          chk("psum2", 64'(out_psum_2), 64'(mon_r.p2));
          chk("psum3", 64'(out_psum_3), 64'(mon_r.p3));
          chk("count", 64'(out_count), 64'(mon_r.cnt));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_p0   = out_psum_0;
      prev_p1   = out_psum_1;
      prev_p2   = out_psum_2;
      prev_p3   = out_psum_3;
      prev_cnt  = out_count;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Random consumer backpressure when enabled.
  logic rand_ready = 1'b0;
  always @(posedge Clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    model_clear_block();
    exp_q.delete();
    repeat (n - 1) tick();
    rst = 1'b1;
  endtask

  // Offer one beat, wait for acceptance, then optionally idle.
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] w,
                           input logic [SW-1:0] s, input logic last,
                           input int gap, output int waited);
    in_act = a; in_weight = w; in_sel = s; in_last = last; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(a, w, s, last);
    repeat (gap) tick();
  endtask

  int w;
  int t;
  int len;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_act = '0; in_weight = '0; in_sel = '0;
    in_last = 1'b0; out_ready = 1'b1;
    model_clear_block();

    // T1: reset held three cycles
    reset_dut(3);
    chk("rst_mac_block", 64'(mac_block), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_psum0", 64'(out_psum_0), 64'(0));
    chk("rst_psum3", 64'(out_psum_3), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    chk("rst_mac_act", 64'(mac_act), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    tick();
    chk("post_rst_mac_block", 64'(mac_block), 64'(1));

    // T2: one block, latency from last beat
    send_beat(8'd3, 8'd4, 2'd0, 1'b0, 0, w);
    send_beat(8'd5, 8'd6, 2'd1, 1'b0, 0, w);
    chk("busy_mid_block", 64'(busy), 64'(1));
    send_beat(8'd2, 8'd7, 2'd0, 1'b1, 0, w);
    chk("lat_e0_valid", 64'(out_valid), 64'(0));
    chk("lat_e0_ready", 64'(in_ready), 64'(0));
    tick();
    chk("lat_e1_valid", 64'(out_valid), 64'(0));
    chk("lat_e1_block", 64'(mac_block), 64'(0));
    tick();
    chk("lat_e2_valid", 64'(out_valid), 64'(1));
    chk("lat_e2_ready", 64'(in_ready), 64'(1));
    chk("t2_psum0", 64'(out_psum_0), 64'(26));
    chk("t2_psum1", 64'(out_psum_1), 64'(30));
    repeat (2) tick();

    // T3: back-to-back single-beat blocks
    send_beat(8'd255, 8'd255, 2'd3, 1'b1, 0, w);
    send_beat(8'd1, 8'd1, 2'd2, 1'b1, 0, w);
    chk("b2b_stall_cycles", 64'(w), 64'(2));
    repeat (4) tick();

    // T4: backpressure stalls FLUSH
    out_ready = 1'b0;
    send_beat(8'd7, 8'd8, 2'd0, 1'b1, 0, w);
    repeat (2) tick();
    chk("bp_first_valid", 64'(out_valid), 64'(1));
    send_beat(8'd2, 8'd2, 2'd1, 1'b1, 0, w);
    repeat (3) begin
      tick();
      chk("bp_stall_block", 64'(mac_block), 64'(1));
      chk("bp_stall_ready", 64'(in_ready), 64'(0));
      chk("bp_stall_psum0", 64'(out_psum_0), 64'(56));
    end
    out_ready = 1'b1;
    repeat (2) tick();
    chk("bp_second_valid", 64'(out_valid), 64'(1));
    chk("bp_second_psum1", 64'(out_psum_1), 64'(4));
    repeat (2) tick();

    // T5: bubbles between beats
    for (int i = 0; i < 4; i++) begin
      send_beat(8'd1, 8'd1, 2'd0, 1'(i == 3), 0, w);
      if (i < 3) begin
        tick();
        chk("bubble_act", 64'(mac_act), 64'(0));
        chk("bubble_weight", 64'(mac_weight), 64'(0));
      end
    end
    repeat (4) tick();

    // T6: reset mid-block discards partial sums
    send_beat(8'd5, 8'd5, 2'd0, 1'b0, 0, w);
    send_beat(8'd9, 8'd9, 2'd1, 1'b0, 0, w);
    reset_dut(1);
    send_beat(8'd2, 8'd3, 2'd1, 1'b1, 0, w);
    repeat (2) tick();
    chk("t6_psum1", 64'(out_psum_1), 64'(6));
    chk("t6_psum0", 64'(out_psum_0), 64'(0));
    chk("t6_count", 64'(out_count), 64'(1));
    repeat (2) tick();

    // Random blocks with random gaps and random consumer readiness
    rand_ready = 1'b1;
    for (int b = 0; b < 150; b++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        send_beat(8'($urandom), 8'($urandom), 2'($urandom), 1'(i == len - 1),
                  $urandom_range(0, 2), w);
      end
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      tick();
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
